// File: rtl/axe5000_ui_pkg.sv
// Shared definitions for the AXE5000 user-input conditioning logic:
// button FSM states, default timing constants and a small state decode helper.
package axe5000_ui_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES   = 20000;
   localparam int DEFAULT_LONG_PRESS_CYCLES = 2000000;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      LONG_HELD,
      RELEASE_WAIT
   } btn_state_t;

   // RELEASE_WAIT still counts as held: the release has not been accepted yet.
   function automatic logic is_held(input btn_state_t s);
      return (s == PRESSED) || (s == LONG_HELD) || (s == RELEASE_WAIT);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs,
// with a configurable reset value so idle levels are known after reset.
module sync_2ff #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk_2m,
   input  logic             combo_reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk_2m) begin
      if (combo_reset) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/user_input_cond.sv
// Conditions the board push button and DIP switches: synchronizes, debounces,
// and produces press / release / long-press strobes plus a debounced switch value.
module user_input_cond
   import axe5000_ui_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
   input  logic       clk_2m,
   input  logic       combo_reset,
   input  logic       USER_BTN,
   input  logic [1:0] DIP_SW,
   output logic       btn_pressed,
   output logic       btn_press_pulse,
   output logic       btn_release_pulse,
   output logic       btn_long_pulse,
   output logic [1:0] dip_sw_db,
   output logic       dip_valid,
   output logic       dip_change_pulse
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int LP_W = $clog2(LONG_PRESS_CYCLES);

   // The button counter starts at 0 on the cycle that enters the wait state,
   // so that cycle is already the first stable sample; acceptance fires on
   // the DEBOUNCE_CYCLES-th stable sample.
   localparam logic [DB_W-1:0] DB_ACCEPT = DB_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LP_W-1:0] LP_LAST   = LP_W'(LONG_PRESS_CYCLES - 1);

   logic       btn_sync;
   logic [1:0] dip_sync;

   sync_2ff #(
      .WIDTH       (1),
      .RESET_VALUE (1'b1)
   ) u_btn_sync (
      .clk_2m      (clk_2m),
      .combo_reset (combo_reset),
      .d           (USER_BTN),
      .q           (btn_sync)
   );

   sync_2ff #(
      .WIDTH       (2),
      .RESET_VALUE (2'b00)
   ) u_dip_sync (
      .clk_2m      (clk_2m),
      .combo_reset (combo_reset),
      .d           (DIP_SW),
      .q           (dip_sync)
   );

   btn_state_t      state;
   btn_state_t      state_next;
   logic [DB_W-1:0] db_cnt;
   logic [DB_W-1:0] db_cnt_next;
   logic [LP_W-1:0] hold_cnt;
   logic [LP_W-1:0] hold_cnt_next;
   logic            from_long;
   logic            from_long_next;
   logic            press_set;
   logic            long_set;
   logic            release_set;
   logic            pressed_set;

   always_ff @(posedge clk_2m) begin
      if (combo_reset) begin
         state             <= IDLE;
         db_cnt            <= '0;
         hold_cnt          <= '0;
         from_long         <= 1'b0;
         btn_pressed       <= 1'b0;
         btn_press_pulse   <= 1'b0;
         btn_long_pulse    <= 1'b0;
         btn_release_pulse <= 1'b0;
      end else begin
         state             <= state_next;
         db_cnt            <= db_cnt_next;
         hold_cnt          <= hold_cnt_next;
         from_long         <= from_long_next;
         btn_pressed       <= pressed_set;
         btn_press_pulse   <= press_set;
         btn_long_pulse    <= long_set;
         btn_release_pulse <= release_set;
      end
   end

   // A release glitch freezes the hold count and remembers whether the long
   // strobe already fired, so returning to the hold never re-issues it.
   always_comb begin
      state_next     = state;
      db_cnt_next    = db_cnt;
      hold_cnt_next  = hold_cnt;
      from_long_next = from_long;
      case (state)
         IDLE: begin
            if (!btn_sync) begin
               state_next  = PRESS_WAIT;
               db_cnt_next = '0;
            end
         end
         PRESS_WAIT: begin
            if (btn_sync) begin
               state_next = IDLE;
            end else if (db_cnt == DB_ACCEPT) begin
               state_next    = PRESSED;
               hold_cnt_next = '0;
            end else begin
               db_cnt_next = db_cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (btn_sync) begin
               state_next     = RELEASE_WAIT;
               db_cnt_next    = '0;
               from_long_next = 1'b0;
            end else if (hold_cnt == LP_LAST) begin
               state_next = LONG_HELD;
            end else begin
               hold_cnt_next = hold_cnt + 1'b1;
            end
         end
         LONG_HELD: begin
            if (btn_sync) begin
               state_next     = RELEASE_WAIT;
               db_cnt_next    = '0;
               from_long_next = 1'b1;
            end
         end
         RELEASE_WAIT: begin
            if (!btn_sync) begin
               state_next = from_long ? LONG_HELD : PRESSED;
            end else if (db_cnt == DB_ACCEPT) begin
               state_next = IDLE;
            end else begin
               db_cnt_next = db_cnt + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      press_set   = (state == PRESS_WAIT)   && (state_next == PRESSED);
      long_set    = (state == PRESSED)      && (state_next == LONG_HELD);
      release_set = (state == RELEASE_WAIT) && (state_next == IDLE);
      pressed_set = is_held(state_next);
   end

   logic [1:0]      dip_cand;
   logic [DB_W-1:0] dip_cnt;

   // Any disagreement restarts the shared stability count; the count then
   // saturates so a long-stable switch never re-triggers a load.
   always_ff @(posedge clk_2m) begin
      if (combo_reset) begin
         dip_cand         <= 2'b00;
         dip_cnt          <= '0;
         dip_sw_db        <= 2'b00;
         dip_valid        <= 1'b0;
         dip_change_pulse <= 1'b0;
      end else begin
         dip_change_pulse <= 1'b0;
         if (dip_sync != dip_cand) begin
            dip_cand <= dip_sync;
            dip_cnt  <= '0;
         end else if (dip_cnt != DB_LAST) begin
            dip_cnt <= dip_cnt + 1'b1;
         end else if ((dip_cand != dip_sw_db) || !dip_valid) begin
            dip_sw_db        <= dip_cand;
            dip_valid        <= 1'b1;
            dip_change_pulse <= dip_valid;
         end
      end
   end

endmodule
